// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM duty ramp sequencer and its period timer.
package pwm_ramp_ctrl_pkg;

  // Duty width of the companion PWM generator.
  localparam int DUTY_W     = 10;
  // Clocks per PWM period (counter wrap of the 10-bit PWM).
  localparam int PWM_PERIOD = 1024;
  // Width of the hold-period counter (HOLD_PERIODS is 1..255).
  localparam int HOLD_W     = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RAMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter width needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next duty one step closer to the target, clamped so it never overshoots.
  // Up-steps use one extra bit so duty+step cannot wrap; down-steps are
  // signed so duty-step cannot underflow past zero.
  function automatic logic [DUTY_W-1:0] ramp_next(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] stp,
    input logic [DUTY_W-1:0] tgt
  );
    logic        [DUTY_W:0] sum;
    logic signed [DUTY_W:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = $signed({1'b0, cur}) - $signed({1'b0, stp});
    if (cur < tgt) begin
      return (sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
    end
    return (diff < $signed({1'b0, tgt})) ? tgt : diff[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_timer.sv
// Free-running PWM period counter; reusable by any block that must act on
// PWM period boundaries. tick is high on the last clock of each period.
module pwm_period_timer
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int PERIOD_CYCLES = PWM_PERIOD,
  parameter int CNT_W         = cnt_width(PERIOD_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == CNT_W'(PERIOD_CYCLES - 1));
  assign tick   = w_last;
  assign count  = r_count;

  // Count 0..PERIOD_CYCLES-1 and wrap, in every state of the user.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty ramp sequencer for the 10-bit PWM: steps the PWM duty toward a
// requested target, loading new values only on PWM period boundaries.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int PERIOD_CYCLES = PWM_PERIOD,
  parameter int HOLD_PERIODS  = 1,
  parameter int W             = DUTY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  input  logic         abort,
  output logic [W-1:0] pwm_data,
  output logic         pwm_load,
  output logic [W-1:0] duty,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = cnt_width(PERIOD_CYCLES);

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_duty;
  logic [W-1:0]     r_tgt;
  logic [W-1:0]     r_stp;
  logic [HOLD_W-1:0] r_hold;
  logic             r_init_load;
  logic             r_done;

  logic             w_tick;
  logic [CNT_W-1:0] w_unused_count;  // phase is not needed here; ticks suffice
  logic [W-1:0]     w_next;
  logic [W-1:0]     w_stp_in;
  logic             w_hold_last;
  logic             w_accept;
  logic             w_fire;

  pwm_period_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .count (w_unused_count)
  );

  assign w_next      = ramp_next(r_duty, r_stp, r_tgt);
  assign w_stp_in    = (step == '0) ? W'(1) : step;
  assign w_hold_last = (r_hold == HOLD_W'(HOLD_PERIODS - 1));
  assign w_accept    = (r_state == ST_IDLE) && start;
  // A load fires on the qualifying tick; abort on that same cycle suppresses it.
  assign w_fire      = (r_state == ST_RAMP) && w_tick && w_hold_last && !abort;

  // The ramp load is issued on the tick cycle itself so it lands exactly on
  // the period boundary; the INIT load comes from a register so nothing is
  // strobed while reset is held.
  assign pwm_load = r_init_load | w_fire;
  assign pwm_data = w_fire ? w_next : r_duty;
  assign duty     = r_duty;
  assign busy     = (r_state == ST_RAMP);
  assign done     = r_done;

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_load) w_state_next = ST_IDLE;
      ST_IDLE: if (start && (target != r_duty)) w_state_next = ST_RAMP;
      ST_RAMP: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_fire && (w_next == r_tgt)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_INIT;
    endcase
  end

  // State register and the one-cycle INIT load that defines the PWM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_init_load <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_load <= (r_state == ST_INIT) && !r_init_load;
    end
  end

  // Latch the request; target and step stay frozen until the ramp ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt <= '0;
      r_stp <= '0;
    end else if (w_accept) begin
      r_tgt <= target;
      r_stp <= w_stp_in;
    end
  end

  // Count whole PWM periods between duty steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_accept) begin
      r_hold <= '0;
    end else if ((r_state == ST_RAMP) && w_tick && !abort) begin
      r_hold <= w_hold_last ? '0 : (r_hold + HOLD_W'(1));
    end
  end

  // Track the duty actually handed to the PWM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
    end else if (w_fire) begin
      r_duty <= w_next;
    end
  end

  // Completion pulse: either the final load just went out, or the request
  // asked for the duty already in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_accept && (target == r_duty)) || (w_fire && (w_next == r_tgt));
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a load scoreboard per instance:
// dut1 uses HOLD_PERIODS=1, dut3 uses HOLD_PERIODS=3, both with 16-clock periods.
module tb_pwm_ramp_ctrl;

  localparam int P = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, start1, abort1, pwm_load1, busy1, done1;
  logic [9:0] target1, step1, pwm_data1, duty1;
  logic       rst3_n, start3, abort3, pwm_load3, busy3, done3;
  logic [9:0] target3, step3, pwm_data3, duty3;

  int checks   = 0;
  int failures = 0;

  pwm_ramp_ctrl #(.PERIOD_CYCLES(P), .HOLD_PERIODS(1), .W(10)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .target(target1), .step(step1),
    .abort(abort1), .pwm_data(pwm_data1), .pwm_load(pwm_load1), .duty(duty1),
    .busy(busy1), .done(done1)
  );

  pwm_ramp_ctrl #(.PERIOD_CYCLES(P), .HOLD_PERIODS(3), .W(10)) dut3 (
    .clk(clk), .rst_n(rst3_n), .start(start3), .target(target3), .step(step3),
    .abort(abort3), .pwm_data(pwm_data3), .pwm_load(pwm_load3), .duty(duty3),
    .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clocks since reset release; the DUT period counter equals k % P.
  int k1 = 0, k3 = 0;
  initial forever begin
    @(posedge clk or negedge rst1_n);
    if (rst1_n !== 1'b1) k1 = 0; else k1++;
  end
  initial forever begin
    @(posedge clk or negedge rst3_n);
    if (rst3_n !== 1'b1) k3 = 0; else k3++;
  end

  // Scoreboards of expected loads and monitor bookkeeping.
  logic [9:0] q1[$];
  logic [9:0] q3[$];
  int load_cnt1 = 0, done_cnt1 = 0, last_load_k1 = 0, done_k1 = 0;
  int load_cnt3 = 0, done_cnt3 = 0, last_load_k3 = 0, done_k3 = 0, gap3 = 0;
  logic done_busy1 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst1_n === 1'b1) begin
      if (pwm_load1 === 1'b1) begin
        $display("dut1 load k=%0d data=%0d", k1, pwm_data1);
        chk("load1_expected", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) chk("load1_data", 32'(pwm_data1), 32'(q1.pop_front()));
        if (load_cnt1 == 0) chk("load1_init_cycle", k1, 1);
        else chk("load1_align", k1 % P, P - 1);
        load_cnt1++;
        last_load_k1 = k1;
      end
      if (done1 === 1'b1) begin
        $display("dut1 done k=%0d duty=%0d", k1, duty1);
        done_cnt1++;
        done_k1    = k1;
        done_busy1 = busy1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst3_n === 1'b1) begin
      if (pwm_load3 === 1'b1) begin
        $display("dut3 load k=%0d data=%0d", k3, pwm_data3);
        chk("load3_expected", 32'(q3.size() > 0), 32'd1);
        if (q3.size() > 0) chk("load3_data", 32'(pwm_data3), 32'(q3.pop_front()));
        if (load_cnt3 == 0) chk("load3_init_cycle", k3, 1);
        else begin
          chk("load3_align", k3 % P, P - 1);
          gap3 = k3 - last_load_k3;
        end
        load_cnt3++;
        last_load_k3 = k3;
      end
      if (done3 === 1'b1) begin
        $display("dut3 done k=%0d duty=%0d", k3, duty3);
        done_cnt3++;
        done_k3 = k3;
      end
    end
  end

  task automatic start_dut1(input logic [9:0] t, input logic [9:0] s);
    @(negedge clk);
    $display("dut1 start target=%0d step=%0d", t, s);
    target1 = t; step1 = s; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic ramp_dut1(input string tag, input logic [9:0] t, input logic [9:0] s,
                           input int wait_cycles);
    int d0;
    d0 = done_cnt1;
    start_dut1(t, s);
    repeat (wait_cycles) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt1, d0 + 1);
    chk({tag, "_done_after_load"}, done_k1, last_load_k1 + 1);
    chk({tag, "_busy_at_done"}, 32'(done_busy1), 32'd0);
    chk({tag, "_duty"}, 32'(duty1), 32'(t));
    chk({tag, "_busy_after"}, 32'(busy1), 32'd0);
    chk({tag, "_all_loads_seen"}, q1.size(), 0);
  endtask

  initial begin
    int base, d0, ks;
    rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; target1 = '0; step1 = '0;
    rst3_n = 1'b0; start3 = 1'b0; abort3 = 1'b0; target3 = '0; step3 = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_pwm_load", 32'(pwm_load1), 32'd0);
    chk("rst_pwm_data", 32'(pwm_data1), 32'd0);
    chk("rst_duty", 32'(duty1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst3_pwm_load", 32'(pwm_load3), 32'd0);

    // Release: one INIT load of 0, then quiet idle.
    q1.push_back(10'd0);
    q3.push_back(10'd0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("init_loads1", load_cnt1, 1);
    chk("init_loads3", load_cnt3, 1);
    chk("idle_busy", 32'(busy1), 32'd0);
    chk("idle_duty", 32'(duty1), 32'd0);

    // Ramp up with clamp at target.
    q1.push_back(10'd30); q1.push_back(10'd60); q1.push_back(10'd90); q1.push_back(10'd100);
    ramp_dut1("up100", 10'd100, 10'd30, 100);

    // Ramp down with clamp, no underflow.
    q1.push_back(10'd60); q1.push_back(10'd20); q1.push_back(10'd5);
    ramp_dut1("down5", 10'd5, 10'd40, 80);

    // Large step clamps at 1020 without wrapping, then step 0 acts as 1.
    q1.push_back(10'd1020);
    ramp_dut1("up1020", 10'd1020, 10'd1023, 40);
    q1.push_back(10'd1021); q1.push_back(10'd1022); q1.push_back(10'd1023);
    ramp_dut1("step0", 10'd1023, 10'd0, 80);

    // Abort on a tick, with an ignored second start mid-ramp.
    q1.push_back(10'd923); q1.push_back(10'd823);
    base = load_cnt1;
    d0   = done_cnt1;
    start_dut1(10'd0, 10'd100);
    for (int i = 0; i < 40 && load_cnt1 < base + 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_ramp_busy", 32'(busy1), 32'd1);
    start_dut1(10'd500, 10'd1);
    for (int i = 0; i < 40 && load_cnt1 < base + 2; i++) @(negedge clk);
    chk("abort_two_loads", load_cnt1, base + 2);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (k1 % P == P - 1) break;
    end
    chk("abort_tick_found", k1 % P, P - 1);
    $display("dut1 abort k=%0d", k1);
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_duty", 32'(duty1), 32'd823);
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_cnt1, d0);
    chk("abort_no_load", load_cnt1, base + 2);
    chk("abort_queue", q1.size(), 0);

    // HOLD_PERIODS=3: loads spaced by three periods.
    q3.push_back(10'd10); q3.push_back(10'd20);
    d0 = done_cnt3;
    @(negedge clk);
    $display("dut3 start target=20 step=10");
    target3 = 10'd20; step3 = 10'd10; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (200) @(negedge clk);
    chk("hold3_gap", gap3, 3 * P);
    chk("hold3_duty", 32'(duty3), 32'd20);
    chk("hold3_done", done_cnt3, d0 + 1);
    chk("hold3_queue", q3.size(), 0);

    // Start equal to current duty (with a coincident abort): done next cycle, no load.
    base = load_cnt3;
    @(negedge clk);
    $display("dut3 start target=20 step=5 with abort");
    target3 = 10'd20; step3 = 10'd5; start3 = 1'b1; abort3 = 1'b1;
    ks = k3;
    @(negedge clk);
    start3 = 1'b0; abort3 = 1'b0;
    repeat (40) @(negedge clk);
    chk("same_done", done_cnt3, d0 + 2);
    chk("same_done_cycle", done_k3, ks + 1);
    chk("same_no_load", load_cnt3, base);
    chk("same_busy", 32'(busy3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
